channel_merge: RTL
==================

// Module: channel_merge
// PURPOSE
//   2-to-1 round-robin merge on the request/valid/data channel protocol: the converging counterpart of the
//   1-to-2 fork. Two producer channels feed one consumer channel through a small output FIFO. Arbitration
//   is fair, and no word is ever dropped or duplicated. Sits where two CSP processes write into one channel.
// PARAMETERS
//   DATA_WIDTH  32  payload width in bits
//   DEPTH       2   output FIFO entries; power of two, >= 2
// PORTS
//   clk                  in   1           single clock; all state on posedge
//   reset_n              in   1           asynchronous active-low reset
//   p0_write_data        in   DATA_WIDTH  producer 0 payload
//   p0_write_valid       in   1           producer 0 has a word
//   p0_write_request     out  1           merge accepts p0 word this cycle
//   p1_write_data        in   DATA_WIDTH  producer 1 payload
//   p1_write_valid       in   1           producer 1 has a word
//   p1_write_request     out  1           merge accepts p1 word this cycle
//   channel_read_data    out  DATA_WIDTH  FIFO head word
//   channel_read_valid   out  1           FIFO non-empty
//   channel_read_request in   1           consumer takes head word this cycle
//   channel_read_src     out  1           origin of head word (only with CHANNEL_MERGE_SRC_EN)
// BEHAVIOUR
//   - Transfer rule, both sides: a word moves on a posedge where valid && request are both high.
//     Requests may depend combinationally on valid. Valid must not depend on request.
//   - State: rr (1b), count (0..DEPTH), wr_ptr/rd_ptr (log2 DEPTH, natural wrap), mem[DEPTH].
//   - Reset (async assert, sync release): count=0, pointers=0, rr=0 (p0 preferred). Outputs at reset:
//     all *_request=0, channel_read_valid=0, channel_read_data=0, channel_read_src=0.
//     A reset mid-operation discards FIFO contents. A producer word offered during reset is not accepted.
//   - space = (count < DEPTH) || (channel_read_request && channel_read_valid). A full FIFO accepts a push
//     in the same cycle as a pop.
//   - Grant (combinational, at most one port per cycle):
//     if !space -> none;
//     else if rr==0 -> p0 if p0_write_valid, else p1 if p1_write_valid;
//     else -> p1 if p1_write_valid, else p0 if p0_write_valid.
//     px_write_request = grant_x.
//   - rr update only on an actual push: rr <= ~granted_port. With no push, rr holds (no idle toggling).
//     Both valid continuously gives strict alternation p0,p1,p0,...
//   - Push writes mem[wr_ptr], wr_ptr++. Pop advances rd_ptr. count += push - pop.
//     Simultaneous push and pop leave count unchanged.
//   - channel_read_valid = (count != 0). channel_read_data = mem[rd_ptr] (registered storage).
//     Latency from input acceptance to output valid: 1 cycle. Throughput: 1 word/cycle.
//   - Data in invalid cycles is don't-care. channel_read_data = 0 when empty (tests rely on this).
// CONFIGURATION
//   CHANNEL_MERGE_SRC_EN defined: a 1-bit source tag (0=p0, 1=p1) is stored with each FIFO entry and
//     driven on channel_read_src alongside channel_read_data. It is 0 when empty.
//   CHANNEL_MERGE_SRC_EN undefined: no channel_read_src port and no tag storage.
//     All other behaviour is identical.
// TESTING
//   1 reset_n low mid-stream with 2 words queued -> valid=0, requests=0; after release FIFO empty, rr=0.
//   2 p0 only, valid held, consumer request=1, words 0xA0..0xA7 -> 8 words out in order, 1/cycle,
//     first word 1 cycle after the first accept.
//   3 p0 and p1 both always valid (0x100+i / 0x200+i), request=1 -> output 0x100,0x200,0x101,0x201,...
//     No stalls.
//   4 consumer request=0, both valid -> exactly DEPTH words accepted, then both requests 0.
//     Raise request for 1 cycle -> one pop plus one push in that same cycle; count stays DEPTH.
//   5 only p1 valid while rr==0 -> p1 granted immediately (no bubble); the next grant prefers p0.
//   6 (CHANNEL_MERGE_SRC_EN) run of scenario 3 -> channel_read_src toggles 0,1,0,1 in step with data.
//     Randomized valid/request run with scoreboard shows no loss or duplication.

Source files
------------

// File: rtl/channel_merge.sv
// 2-to-1 round-robin merge of two request/valid/data producer channels into one consumer channel via a small FIFO.
// Optional feature macro: CHANNEL_MERGE_SRC_EN adds a per-word source tag output (channel_read_src).
module channel_merge #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] p0_write_data,
  input  logic                  p0_write_valid,
  output logic                  p0_write_request,
  input  logic [DATA_WIDTH-1:0] p1_write_data,
  input  logic                  p1_write_valid,
  output logic                  p1_write_request,
  output logic [DATA_WIDTH-1:0] channel_read_data,
  output logic                  channel_read_valid,
  input  logic                  channel_read_request
`ifdef CHANNEL_MERGE_SRC_EN
  ,
  output logic                  channel_read_src
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]           count_q, count_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  rr_q, rr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  non_empty_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  space_s;
  logic                  grant0_s;
  logic                  grant1_s;
  logic [DATA_WIDTH-1:0] push_data_s;

  assign non_empty_s = (count_q != {(AW+1){1'b0}});
  assign pop_s       = channel_read_request && non_empty_s;
  // A full FIFO still has room when the head word leaves in the same cycle.
  assign space_s     = (count_q < (AW+1)'(DEPTH)) || pop_s;

  // Round-robin grant; held off while reset is asserted so no word is taken during reset.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (!reset_n || !space_s) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (!rr_q) begin
      if (p0_write_valid) begin
        grant0_s = 1'b1;
      end else begin
        grant1_s = p1_write_valid;
      end
    end else begin
      if (p1_write_valid) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = p0_write_valid;
      end
    end
  end

  assign p0_write_request = grant0_s;
  assign p1_write_request = grant1_s;
  assign push_s           = grant0_s || grant1_s;
  assign push_data_s      = grant1_s ? p1_write_data : p0_write_data;

  // Next-state for pointers, occupancy and the round-robin preference.
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    rr_d     = push_s ? grant0_s : rr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= {(AW+1){1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      rr_q     <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rr_q     <= rr_d;
    end
  end

  // Payload storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= push_data_s;
    end
  end

  assign channel_read_valid = non_empty_s;
  assign channel_read_data  = non_empty_s ? mem_q[rd_ptr_q] : {DATA_WIDTH{1'b0}};

`ifdef CHANNEL_MERGE_SRC_EN
  logic src_q [DEPTH];

  // Source tag storage, written alongside the payload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        src_q[i] <= 1'b0;
      end
    end else if (push_s) begin
      src_q[wr_ptr_q] <= grant1_s;
    end
  end

  assign channel_read_src = non_empty_s ? src_q[rd_ptr_q] : 1'b0;
`endif

endmodule
